// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style 4-bit bus decoder: FSM states,
// power-on init nibbles and the command codes that affect timing/address.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_PWR = 3'd0,
    ST_INIT_A   = 3'd1,
    ST_INIT_B   = 3'd2,
    ST_INIT_C   = 3'd3,
    ST_INIT_D   = 3'd4,
    ST_HIGH_NIB = 3'd5,
    ST_LOW_NIB  = 3'd6
  } lcd_state_e;

  localparam logic [3:0] INIT_NIB_3 = 4'h3;
  localparam logic [3:0] INIT_NIB_2 = 4'h2;

  localparam logic [7:0] CMD_CLEAR          = 8'h01;
  localparam logic [7:0] CMD_HOME           = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM_MASK = 8'h80;

  // Clear (0x01) and Return Home (0x02/0x03) are the long-execution commands.
  function automatic logic is_slow_cmd(input logic [7:0] b);
    return (b == CMD_CLEAR) || ((b & 8'hFE) == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_enable_strobe.sv
// E-strobe front end: edge detection, high-phase width count and capture of
// the nibble/RS/RW seen during the high phase.
module lcd_enable_strobe #(
  parameter int T_EWIDTH = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [3:0] i_data,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_short,
  output logic       o_rs_change,
  output logic       o_rs,
  output logic       o_rw,
  output logic [3:0] o_nib
);

  logic        r_armed;
  logic        r_e_prev;
  logic [31:0] r_ehigh_cnt;
  logic [3:0]  r_nib;
  logic        r_rs;
  logic        r_rw;

  // Edges only count once E has been seen low after reset, so a strobe
  // already in progress at reset release is discarded.
  assign o_rise      = r_armed & ~r_e_prev & i_e;
  assign o_fall      = r_armed & r_e_prev & ~i_e;
  assign o_short     = o_fall & (r_ehigh_cnt < 32'(T_EWIDTH));
  assign o_rs_change = r_armed & r_e_prev & i_e & (i_rs != r_rs);
  assign o_rs        = r_rs;
  assign o_rw        = r_rw;
  assign o_nib       = r_nib;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_armed     <= 1'b0;
      r_e_prev    <= 1'b0;
      r_ehigh_cnt <= '0;
      r_nib       <= '0;
      r_rs        <= 1'b0;
      r_rw        <= 1'b0;
    end else begin
      r_e_prev <= i_e;
      if (!i_e) begin
        r_armed     <= 1'b1;
        r_ehigh_cnt <= '0;
      end else begin
        r_nib <= i_data;
        r_rs  <= i_rs;
        // Any read cycle within one high phase marks the whole strobe as a read.
        r_rw  <= r_e_prev ? (r_rw | i_rw) : i_rw;
        if (r_ehigh_cnt != 32'hFFFF_FFFF) begin
          r_ehigh_cnt <= r_ehigh_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_bus_decoder.sv
// Passive decoder for a 4-bit LCD bus: tracks the power-on init sequence,
// reassembles bytes, follows the DDRAM cursor and flags timing violations.
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int T_POWERON = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_NIB     = 50,
  parameter int T_EWIDTH  = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oIsData,
  output logic       oByteValid,
  output logic       oInitDone,
  output logic [6:0] oDDRAMAddr,
  output logic       oTimingError
);

  logic       w_rise, w_fall, w_short, w_rs_change, w_rs, w_rw;
  logic [3:0] w_nib;

  lcd_enable_strobe #(.T_EWIDTH(T_EWIDTH)) u_strobe (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_e         (iLCD_Enabled),
    .i_rs        (iLCD_RegisterSelect),
    .i_rw        (iLCD_ReadWrite),
    .i_data      (iLCD_Data),
    .o_rise      (w_rise),
    .o_fall      (w_fall),
    .o_short     (w_short),
    .o_rs_change (w_rs_change),
    .o_rs        (w_rs),
    .o_rw        (w_rw),
    .o_nib       (w_nib)
  );

  lcd_state_e  r_state, w_state_next;
  logic [31:0] r_gap, r_req_gap, w_req_next;
  logic [3:0]  r_high;
  logic        r_high_rs;
  logic [7:0]  r_byte;
  logic        r_is_data, r_valid, r_init_done, r_err;
  logic [6:0]  r_addr, w_addr_next;

  logic        w_accept, w_init_err, w_init_done_set, w_high_ld, w_byte_ld;
  logic        w_err_set;
  logic [7:0]  w_byte;
  logic [3:0]  w_init_exp;
  lcd_state_e  w_init_next;
  logic [31:0] w_init_gap;

  assign w_accept = w_fall & ~w_rw;
  assign w_byte   = {r_high, w_nib};

  always_comb begin
    w_init_exp  = INIT_NIB_3;
    w_init_next = ST_INIT_B;
    w_init_gap  = 32'(T_INIT1);
    case (r_state)
      ST_INIT_B: begin w_init_next = ST_INIT_C;   w_init_gap = 32'(T_INIT2); end
      ST_INIT_C: begin w_init_next = ST_INIT_D;   w_init_gap = 32'(T_CMD);   end
      ST_INIT_D: begin
        w_init_exp  = INIT_NIB_2;
        w_init_next = ST_HIGH_NIB;
        w_init_gap  = 32'(T_CMD);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_req_next      = r_req_gap;
    w_init_err      = 1'b0;
    w_init_done_set = 1'b0;
    w_high_ld       = 1'b0;
    w_byte_ld       = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_HIGH_NIB: begin
          w_high_ld    = 1'b1;
          w_state_next = ST_LOW_NIB;
          w_req_next   = 32'(T_NIB);
        end
        ST_LOW_NIB: begin
          w_byte_ld    = 1'b1;
          w_state_next = ST_HIGH_NIB;
          w_req_next   = (!w_rs && is_slow_cmd(w_byte)) ? 32'(T_CLEAR) : 32'(T_CMD);
        end
        default: begin
          // WAIT_PWR's first strobe is judged exactly like INIT_A.
          if (w_nib == w_init_exp && !w_rs) begin
            w_state_next    = w_init_next;
            w_req_next      = w_init_gap;
            w_init_done_set = (r_state == ST_INIT_D);
          end else begin
            w_init_err   = 1'b1;
            w_state_next = ST_INIT_A;
            w_req_next   = 32'(T_CMD);
          end
        end
      endcase
    end
  end

  always_comb begin
    w_addr_next = r_addr;
    if (w_rs) begin
      w_addr_next = r_addr + 7'd1;
    end else if ((w_byte & CMD_SET_DDRAM_MASK) != 8'h00) begin
      w_addr_next = w_byte[6:0];
    end else if (is_slow_cmd(w_byte)) begin
      w_addr_next = 7'd0;
    end
  end

  assign w_err_set = w_short | w_rs_change | (w_fall & w_rw) | w_init_err
                   | (w_rise & (r_gap < r_req_gap))
                   | (w_byte_ld & (w_rs != r_high_rs));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_WAIT_PWR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_gap       <= '0;
      r_req_gap   <= 32'(T_POWERON);
      r_high      <= '0;
      r_high_rs   <= 1'b0;
      r_byte      <= '0;
      r_is_data   <= 1'b0;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
      r_addr      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_req_gap <= w_req_next;
      r_valid   <= w_byte_ld;
      if (w_accept) begin
        r_gap <= '0;
      end else if (r_gap != 32'hFFFF_FFFF) begin
        r_gap <= r_gap + 32'd1;
      end
      if (w_high_ld) begin
        r_high    <= w_nib;
        r_high_rs <= w_rs;
      end
      if (w_byte_ld) begin
        r_byte    <= w_byte;
        r_is_data <= w_rs;
        r_addr    <= w_addr_next;
      end
      if (w_init_done_set) begin
        r_init_done <= 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign oByte        = r_byte;
  assign oIsData      = r_is_data;
  assign oByteValid   = r_valid;
  assign oInitDone    = r_init_done;
  assign oDDRAMAddr   = r_addr;
  assign oTimingError = r_err;

endmodule

// File: doc/lcd_bus_decoder.md
LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- T_POWERON, 750000: min cycles from reset release to first strobe (15 ms at 50 MHz).
- T_INIT1, 205000: min gap after first init nibble.
- T_INIT2, 5000: min gap after second init nibble.
- T_CMD, 2000: min gap after a normal byte or third/fourth init nibble.
- T_CLEAR, 82000: min gap after a Clear (0x01) or Return Home (0x02/0x03) byte.
- T_NIB, 50: min gap between high and low nibble of one byte.
- T_EWIDTH, 12: min Enable-high cycles.
REQ-002 Clock, input, 1: clock; all logic on rising edge.
REQ-003 Reset, input, 1: reset; synchronous, active-high.
REQ-004 iLCD_Enabled, input, 1: LCD E strobe, same clock domain, no synchronizer.
REQ-005 iLCD_RegisterSelect, input, 1: 0 = command, 1 = data.
REQ-006 iLCD_ReadWrite, input, 1: 0 = write.
REQ-007 iLCD_Data, input, 4: nibble bus.
REQ-008 oByte, output, 8: last assembled byte.
REQ-009 oIsData, output, 1: RS of oByte.
REQ-010 oByteValid, output, 1: one-cycle pulse when oByte/oIsData are updated.
REQ-011 oInitDone, output, 1: power-on nibble sequence completed.
REQ-012 oDDRAMAddr, output, 7: tracked cursor address.
REQ-013 oTimingError, output, 1: sticky protocol/timing violation flag.

Function
REQ-014 Strobe: E-high counter; nibble and RS registered every cycle E is sampled high; falling edge = E high at previous edge, low at current edge.
REQ-015 Acceptance: a nibble SHALL be accepted at the falling-edge clock edge using the last registered high-phase nibble/RS; outputs update at that edge.
REQ-016 E-high count < T_EWIDTH at falling edge SHALL set error; nibble still accepted.
REQ-017 RS change while E high SHALL set error; RS captured at last high cycle is used.
REQ-018 Strobes with RW=1 SHALL set error and be ignored (no FSM advance).
REQ-019 Gap counter: 32-bit, cleared at each accepted falling edge, saturating; on E rising edge, counter < current required gap SHALL set error; strobe still processed.
REQ-020 FSM states: WAIT_PWR, INIT_A, INIT_B, INIT_C, INIT_D, HIGH_NIB, LOW_NIB.
- WAIT_PWR: required gap T_POWERON; first accepted strobe enters INIT_A processing.
- INIT_A/B/C expect 0x3; INIT_D expects 0x2; all RS=0; required gaps after them T_INIT1, T_INIT2, T_CMD, T_CMD.
REQ-021 Wrong nibble or RS=1 during INIT_x SHALL set error and return FSM to INIT_A expecting 0x3; init nibbles never pulse oByteValid.
REQ-022 oInitDone SHALL rise at acceptance of 0x2 in INIT_D; FSM enters HIGH_NIB.
REQ-023 HIGH_NIB: store bits 7:4; go to LOW_NIB; required gap T_NIB.
REQ-024 LOW_NIB: oByte = {high, nibble}; oIsData = RS; oByteValid pulses one cycle; return to HIGH_NIB.
- Required gap T_CLEAR for command 0x01/0x02/0x03, else T_CMD.
REQ-025 RS differing between high and low nibble SHALL set error; low-nibble RS is reported.
REQ-026 DDRAM address updates on each reported byte:
- command 1aaaaaaa loads aaaaaaa;
- command 0x01/0x02/0x03 clears to 0;
- data increments modulo 128 (0x7F wraps to 0x00);
- other commands leave it unchanged.
REQ-027 oTimingError SHALL clear only on Reset.

Reset
REQ-028 Reset SHALL load, regardless of strobe in progress:
- outputs: oByte=0, oIsData=0, oByteValid=0, oInitDone=0, oDDRAMAddr=0, oTimingError=0;
- internal: FSM=WAIT_PWR, gap counter 0, E-high counter 0, previous-E register 0.
REQ-029 A strobe with E high at reset release SHALL be ignored until E is seen low.

Structure
REQ-030 Shared package lcd_pkg SHALL hold FSM state encodings, init nibble constants (0x3, 0x2), and command codes 0x01/0x02/0x80 mask.
REQ-031 Sub-module lcd_enable_strobe SHALL contain edge detection, E-high width counter and nibble/RS capture; the parent holds FSM, gap check and address logic.

Verification
REQ-032 Legal init (0x3@+750001, 0x3@+205001, 0x3@+5001, 0x2@+2001, E width 12) -> oInitDone=1, oTimingError=0, no oByteValid.
REQ-033 After init, RS=1 nibbles 0x4,0x1 (gap 50) -> oByte=0x41, oIsData=1, one-cycle oByteValid, oDDRAMAddr 0->1.
REQ-034 Command 0x01 then next strobe after 2000 cycles -> oDDRAMAddr=0, oTimingError=1; repeated with 82000-cycle gap -> no error.
REQ-035 Command 0xFF then data byte -> oDDRAMAddr 0x7F then 0x00; E width 11 -> error set, byte still reported.
REQ-036 Init nibble 0x2 in INIT_B -> error, FSM back to INIT_A; Reset asserted mid-byte -> all outputs 0, next high nibble treated as WAIT_PWR strobe.
